// File: rtl/spi_ram_pkg.sv
// Shared sizes, state encoding and command helpers for the SPI slave and the RAM it drives.
package spi_ram_pkg;

  localparam int INST_SIZE = 16;
  localparam int DATA_SIZE = 8;
  localparam int ADDR_SIZE = 7;
  localparam int MEM_DEPTH = 128;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WAIT_RD,
    SEND,
    DONE
  } state_e;

  // Command word: [15] = 1 write / 0 read, [14:8] = address, [7:0] = write data.
  function automatic logic cmd_is_write(input logic [INST_SIZE-1:0] cmd);
    return cmd[INST_SIZE-1];
  endfunction

endpackage

// File: rtl/spi_slave.sv
// SPI slave: collects a 16-bit command from MOSI and, for reads, returns one byte on MISO.
// Optional read timeout in WAIT_RD is enabled by defining SPI_RD_TIMEOUT_EN.
module spi_slave #(
  parameter int INST_SIZE  = spi_ram_pkg::INST_SIZE,
  parameter int DATA_SIZE  = spi_ram_pkg::DATA_SIZE,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [INST_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  import spi_ram_pkg::*;

  localparam int CNT_W = $clog2(INST_SIZE);
  // The 16th bit is merged combinationally on capture, so only 15 bits need storing.
  localparam int SH_W  = INST_SIZE - 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [INST_SIZE-1:0] rx_data_q, rx_data_d;
  logic [INST_SIZE-1:0] rx_word;
  logic                 rx_valid_q, rx_valid_d;
  logic                 miso_q, miso_d;
  logic                 abort;

`ifdef SPI_RD_TIMEOUT_EN
  localparam int TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  logic [TO_W-1:0]      timeout_q, timeout_d;
`endif

  assign rx_word = {shift_q, MOSI};
  assign abort   = SS_n && (state_q == RECV || state_q == WAIT_RD || state_q == SEND);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
    timeout_d  = '0;
`endif
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) begin
            shift_d = SH_W'(MOSI);
            cnt_d   = CNT_W'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          shift_d = rx_word[SH_W-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(INST_SIZE - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = cmd_is_write(rx_word) ? DONE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          // rx_valid_q marks the first WAIT_RD cycle, where tx_valid may be stale.
          if (!rx_valid_q) begin
            if (tx_valid) begin
              shift_d = SH_W'(tx_data);
              miso_d  = tx_data[DATA_SIZE-1];
              cnt_d   = '0;
              state_d = SEND;
            end
`ifdef SPI_RD_TIMEOUT_EN
            else if (timeout_q == TO_W'(RD_TIMEOUT - 1)) begin
              state_d = DONE;
            end else begin
              timeout_d = timeout_q + 1'b1;
            end
`endif
          end
        end
        SEND: begin
          if (cnt_q == CNT_W'(DATA_SIZE - 1)) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = DONE;
          end else begin
            miso_d  = shift_q[DATA_SIZE-2];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (SS_n) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
      timeout_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
`ifdef SPI_RD_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write, read, stale tx_valid, abort, reset in SEND, read timeout.
module tb_spi_slave;
  import spi_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave #(
    .INST_SIZE (16),
    .DATA_SIZE (8),
    .RD_TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Shift the first n bits of w (MSB first) with SS_n low; MISO must stay 0, no early strobe.
  task automatic send_bits(input logic [15:0] w, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      SS_n = 1'b0;
      MOSI = w[15-i];
      tick();
      check({tag, " miso_recv"}, 32'(MISO), 32'd0);
      if (i < 15) check({tag, " rxv_early"}, 32'(rx_valid), 32'd0);
    end
  endtask

  // Called right after the edge that entered SEND: expects bits 7..0 then MISO=0 in DONE.
  task automatic expect_byte(input logic [7:0] b, input string tag);
    for (int k = 7; k >= 0; k--) begin
      check({tag, " miso_bit"}, 32'(MISO), 32'(b[k]));
      check_state({tag, " st_send"}, SEND);
      tick();
    end
    check({tag, " miso_end"}, 32'(MISO), 32'd0);
    check_state({tag, " st_done"}, DONE);
  endtask

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tick();
    tick();
    check("rst miso", 32'(MISO), 32'd0);
    check("rst rxv", 32'(rx_valid), 32'd0);
    check("rst rxd", 32'(rx_data), 32'h0);
    check_state("rst st", IDLE);
    rst_n = 1'b1;
    tick();
    check_state("idle st", IDLE);
    $display("reset done");

    // Write frame 0x8A5C
    send_bits(16'h8A5C, 16, "wr");
    check("wr rxv", 32'(rx_valid), 32'd1);
    check("wr rxd", 32'(rx_data), 32'h8A5C);
    check_state("wr st", DONE);
    MOSI = 1'b1;
    tick();
    check("wr rxv_once", 32'(rx_valid), 32'd0);
    check("wr miso_done", 32'(MISO), 32'd0);
    check_state("wr st_hold", DONE);
    tick();
    check_state("wr st_hold2", DONE);
    check("wr rxd_hold", 32'(rx_data), 32'h8A5C);
    SS_n = 1'b1;
    tick();
    check_state("wr st_idle", IDLE);
    $display("write frame 0x8A5C rx_data=0x%h", rx_data);

    // Read frame 0x0A00, RAM answers 0x5C one cycle after rx_valid
    send_bits(16'h0A00, 16, "rd");
    check("rd rxv", 32'(rx_valid), 32'd1);
    check("rd rxd", 32'(rx_data), 32'h0A00);
    check_state("rd st_wait", WAIT_RD);
    tick();
    check_state("rd st_wait2", WAIT_RD);
    check("rd rxv_once", 32'(rx_valid), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h5C;
    tick();
    expect_byte(8'h5C, "rd");
    SS_n = 1'b1;
    tick();
    check_state("rd st_idle", IDLE);
    $display("read frame 0x0A00 returned 0x5C");

    // Stale tx_valid still high: first WAIT_RD cycle must ignore it
    tx_data = 8'hFF;
    send_bits(16'h0B00, 16, "stale");
    check("stale rxd", 32'(rx_data), 32'h0B00);
    check_state("stale st_wait", WAIT_RD);
    tick();
    check_state("stale st_ignored", WAIT_RD);
    check("stale miso", 32'(MISO), 32'd0);
    tx_data = 8'hA3;
    tick();
    expect_byte(8'hA3, "stale");
    tx_valid = 1'b0;
    SS_n = 1'b1;
    tick();
    $display("stale tx_valid read frame 0x0B00 returned 0xA3");

    // Abort after 7 bits, then back-to-back full frame
    send_bits(16'hFFFF, 7, "abort");
    SS_n = 1'b1;
    tick();
    check("abort rxv", 32'(rx_valid), 32'd0);
    check_state("abort st", IDLE);
    check("abort rxd_hold", 32'(rx_data), 32'h0B00);
    send_bits(16'h8133, 16, "b2b");
    check("b2b rxv", 32'(rx_valid), 32'd1);
    check("b2b rxd", 32'(rx_data), 32'h8133);
    check_state("b2b st", DONE);
    SS_n = 1'b1;
    tick();
    $display("aborted frame, then frame 0x8133 rx_data=0x%h", rx_data);

    // Reset while MISO carries bit 4
    send_bits(16'h0C00, 16, "rstsend");
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h5C;
    tick();
    tick();
    tick();
    tick();
    check("rstsend b4", 32'(MISO), 32'd1);
    check_state("rstsend st", SEND);
    rst_n = 1'b0;
    #1;
    check("rstsend miso", 32'(MISO), 32'd0);
    check("rstsend rxv", 32'(rx_valid), 32'd0);
    check("rstsend rxd", 32'(rx_data), 32'h0);
    check_state("rstsend st_idle", IDLE);
    tx_valid = 1'b0;
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    $display("reset during SEND bit 4");

    // Read with no response
    send_bits(16'h0D00, 16, "to");
    check_state("to st_wait", WAIT_RD);
`ifdef SPI_RD_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      check_state("to st_waiting", WAIT_RD);
    end
    tick();
    check_state("to st_done", DONE);
    check("to miso", 32'(MISO), 32'd0);
    $display("read timeout reached DONE");
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      check_state("to st_waiting", WAIT_RD);
      check("to miso", 32'(MISO), 32'd0);
    end
    $display("read without timeout still waiting");
`endif
    SS_n = 1'b1;
    tick();
    check_state("to st_idle", IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter INST_SIZE, 16, command word width (bit 15 = R/W, bits 14:8 = address, bits 7:0 = write data).
REQ-002 Parameter DATA_SIZE, 8, read-data width returned on MISO.
REQ-003 Parameter RD_TIMEOUT, 4, cycles to wait for read data (used only under SPI_RD_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; SPI serial clock, all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SS_n  input  1  slave select, active-low; frame lasts while low.
REQ-007 MOSI  input  1  serial command in, MSB first.
REQ-008 MISO  output  1  serial read data out, MSB first, registered.
REQ-009 rx_data  output  INST_SIZE  assembled command word to RAM.
REQ-010 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-011 tx_data  input  DATA_SIZE  read data from RAM.
REQ-012 tx_valid  input  1  RAM read-data valid (level; may remain high from an earlier read).

Function
REQ-013 States SHALL be IDLE, RECV, WAIT_RD, SEND, DONE.
REQ-014 IDLE: SS_n low at posedge -> MOSI captured as bit 15, bit count = 1, go RECV.
REQ-015 RECV: each posedge with SS_n low shifts MOSI into the LSB; on capture of the 16th bit rx_data is loaded and rx_valid is high in the following cycle for exactly one cycle.
REQ-016 At that same edge: bit 15 = 1 (write) -> DONE; bit 15 = 0 (read) -> WAIT_RD.
REQ-017 WAIT_RD SHALL ignore tx_valid in its first cycle (the cycle rx_valid is high); from the second cycle, tx_valid high at posedge -> tx_data loaded into the shift register, MISO <= tx_data[7], go SEND.
REQ-018 SEND: next 7 posedges drive MISO = bits 6..0 in turn; the edge after bit 0 sets MISO = 0 and goes to DONE.
REQ-019 DONE: MOSI ignored, MISO = 0, no rx_valid; SS_n high -> IDLE.
REQ-020 SS_n high at any posedge in RECV, WAIT_RD, SEND SHALL abort to IDLE, MISO = 0, no rx_valid, partial bits discarded.
REQ-021 MISO SHALL be 0 in every state except SEND.
REQ-022 rx_data SHALL hold its last value between strobes.
REQ-023 Back-to-back frames: SS_n high for one cycle then low SHALL start a new frame cleanly.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, MISO = 0, rx_valid = 0, rx_data = 0, bit count = 0, shift register = 0, timeout count = 0, including mid-frame.

Configuration
REQ-025 SPI_RD_TIMEOUT_EN defined: if WAIT_RD sees no qualifying tx_valid within RD_TIMEOUT cycles after its ignored first cycle, go DONE with MISO = 0.
REQ-026 SPI_RD_TIMEOUT_EN undefined: WAIT_RD waits indefinitely; no timeout counter is synthesised.

Structure
REQ-027 Package spi_ram_pkg SHALL hold INST_SIZE, DATA_SIZE, ADDR_SIZE = 7, MEM_DEPTH = 128 and the state enum, shared with the RAM and top level.
REQ-028 No sub-module: FSM, bit counter and shift registers live in spi_slave.

Verification
REQ-029 Write frame 0x8A5C -> rx_data = 0x8A5C, rx_valid high exactly one cycle, MISO stays 0, DONE until SS_n high.
REQ-030 Read frame 0x0A00, model returns 0x5C with tx_valid one cycle after rx_valid -> MISO sequence 0,1,0,1,1,1,0,0, then 0.
REQ-031 Stale tx_valid = 1 held from prior read during a new read frame -> ignored in first WAIT_RD cycle, data taken from the fresh response.
REQ-032 SS_n high after 7 bits -> no rx_valid, IDLE next cycle; following full frame 0x8133 decoded correctly.
REQ-033 rst_n low during SEND bit 4 -> MISO = 0, rx_valid = 0, IDLE immediately.
REQ-034 With SPI_RD_TIMEOUT_EN, read with no tx_valid -> DONE after 4 cycles, MISO 0; without it -> remains in WAIT_RD.
